// File: rtl/alu_result_checker.sv
// ---------------------------------------------------------------------------
// alu_result_checker
//
// Checks a stream of ALU results against locally computed expected values.
// A run starts with a one-cycle start pulse and takes EXPECT_COUNT vectors.
// Each accepted vector {op, a, b, c} is registered once. On the next edge it
// is compared: vec_cnt counts it, and if c is wrong fail_cnt counts it and
// mismatch pulses for one cycle. After the last compare the checker sits in
// DONE with pass = (fail_cnt == 0) until the next start.
//
// Optional feature: define FIRST_FAIL_CAPTURE_EN to add ports that latch the
// first failing vector of each run (ff_valid, ff_op, ff_a, ff_b, ff_c).
//
// Ports
//   clk       : sole clock, rising edge
//   rst_n     : synchronous active-low reset
//   start     : one-cycle pulse that begins a run (ignored while busy)
//   in_valid  : vector present on op/a/b/c
//   in_ready  : checker accepts a vector this cycle
//   op        : 00 XOR, 01 AND, 10 OR, 11 ADD (carry discarded)
//   a, b      : operands applied to the unit under test
//   c         : result returned by the unit under test
//   busy      : run in progress
//   done      : run complete, held until next start or reset
//   pass      : valid while done, 1 iff no vector failed
//   mismatch  : one-cycle pulse per failing vector
//   vec_cnt   : vectors compared in the current run (saturating)
//   fail_cnt  : vectors failed in the current run (saturating)
// ---------------------------------------------------------------------------
module alu_result_checker #(
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 16,
  parameter int EXPECT_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] fail_cnt
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic             ff_valid,
  output logic [1:0]       ff_op,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_c
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXPECT_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] acc_cnt_reg;
  logic [CNT_W-1:0] vec_cnt_reg;
  logic [CNT_W-1:0] fail_cnt_reg;
  logic             pipe_valid_reg;
  logic             mismatch_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] c_reg;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic             ff_valid_reg;
  logic [1:0]       ff_op_reg;
  logic [WIDTH-1:0] ff_a_reg;
  logic [WIDTH-1:0] ff_b_reg;
  logic [WIDTH-1:0] ff_c_reg;
`endif

  logic             start_run;
  logic             accept;
  logic             last_cmp_done;
  logic             cmp_fail;
  logic [WIDTH-1:0] xor_w;
  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] or_w;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] expected;

  // start only has an effect outside RUN; in_ready is 0 outside RUN, so a
  // vector presented together with start is never taken.
  assign start_run = start && (state_reg != S_RUN);
  assign accept    = in_valid && in_ready;

  // All vectors taken and the pipeline stage has drained: the final compare
  // happened on the previous edge.
  assign last_cmp_done = (acc_cnt_reg == EXP_CNT) && !pipe_valid_reg;

  // ---------------- expected result ----------------
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign xor_w[gi] = a_reg[gi] ^ b_reg[gi];
      assign and_w[gi] = a_reg[gi] & b_reg[gi];
      assign or_w[gi]  = a_reg[gi] | b_reg[gi];
    end
  endgenerate

  // WIDTH-bit sum: the carry out falls off.
  assign sum_w = a_reg + b_reg;

  always_comb begin
    expected = xor_w;
    case (op_reg)
      2'b00:   expected = xor_w;
      2'b01:   expected = and_w;
      2'b10:   expected = or_w;
      default: expected = sum_w;
    endcase
  end

  assign cmp_fail = (c_reg != expected);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_cmp_done) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    in_ready = 1'b0;
    pass     = 1'b0;
    case (state_reg)
      S_RUN: begin
        busy     = 1'b1;
        in_ready = (acc_cnt_reg < EXP_CNT);
      end
      S_DONE: begin
        done = 1'b1;
        pass = (fail_cnt_reg == '0);
      end
      default: ;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt_reg    <= '0;
      vec_cnt_reg    <= '0;
      fail_cnt_reg   <= '0;
      pipe_valid_reg <= 1'b0;
      mismatch_reg   <= 1'b0;
      op_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      c_reg          <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
      ff_valid_reg   <= 1'b0;
      ff_op_reg      <= '0;
      ff_a_reg       <= '0;
      ff_b_reg       <= '0;
      ff_c_reg       <= '0;
`endif
    end else begin
      mismatch_reg <= 1'b0;
      if (start_run) begin
        acc_cnt_reg    <= '0;
        vec_cnt_reg    <= '0;
        fail_cnt_reg   <= '0;
        pipe_valid_reg <= 1'b0;
        op_reg         <= '0;
        a_reg          <= '0;
        b_reg          <= '0;
        c_reg          <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
        ff_valid_reg   <= 1'b0;
        ff_op_reg      <= '0;
        ff_a_reg       <= '0;
        ff_b_reg       <= '0;
        ff_c_reg       <= '0;
`endif
      end else begin
        // Single capture stage; it reloads on every accept so a vector can
        // be taken every cycle while the previous one is being compared.
        pipe_valid_reg <= accept;
        if (accept) begin
          acc_cnt_reg <= acc_cnt_reg + 1'b1;
          op_reg      <= op;
          a_reg       <= a;
          b_reg       <= b;
          c_reg       <= c;
        end

        if (pipe_valid_reg) begin
          if (vec_cnt_reg != CNT_MAX) begin
            vec_cnt_reg <= vec_cnt_reg + 1'b1;
          end
          if (cmp_fail) begin
            mismatch_reg <= 1'b1;
            if (fail_cnt_reg != CNT_MAX) begin
              fail_cnt_reg <= fail_cnt_reg + 1'b1;
            end
`ifdef FIRST_FAIL_CAPTURE_EN
            if (!ff_valid_reg) begin
              ff_valid_reg <= 1'b1;
              ff_op_reg    <= op_reg;
              ff_a_reg     <= a_reg;
              ff_b_reg     <= b_reg;
              ff_c_reg     <= c_reg;
            end
`endif
          end
        end
      end
    end
  end

  assign mismatch = mismatch_reg;
  assign vec_cnt  = vec_cnt_reg;
  assign fail_cnt = fail_cnt_reg;

`ifdef FIRST_FAIL_CAPTURE_EN
  assign ff_valid = ff_valid_reg;
  assign ff_op    = ff_op_reg;
  assign ff_a     = ff_a_reg;
  assign ff_b     = ff_b_reg;
  assign ff_c     = ff_c_reg;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// ---------------------------------------------------------------------------
// tb_alu_result_checker
//
// Three checker instances share one set of inputs:
//   d4 : defaults (CNT_W=16, EXPECT_COUNT=4)
//   d1 : EXPECT_COUNT=1 for the single-vector run
//   ds : CNT_W=2, EXPECT_COUNT=3 for the saturating all-fail run
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_result_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] a, b, c;

  always #5 clk = ~clk;

  logic        rdy4, busy4, done4, pass4, mis4;
  logic [15:0] vec4, fail4;
  logic        rdy1, busy1, done1, pass1, mis1;
  logic [15:0] vec1, fail1;
  logic        rdys, busys, dones, passs, miss;
  logic [1:0]  vecs, fails;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic       ffv4, ffv1, ffvs;
  logic [1:0] ffop4, ffop1, ffops;
  logic [7:0] ffa4, ffb4, ffc4, ffa1, ffb1, ffc1, ffas, ffbs, ffcs;
`endif

  alu_result_checker #(.WIDTH(8), .CNT_W(16), .EXPECT_COUNT(4)) d4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(rdy4), .op(op), .a(a), .b(b), .c(c),
    .busy(busy4), .done(done4), .pass(pass4), .mismatch(mis4),
    .vec_cnt(vec4), .fail_cnt(fail4)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .ff_valid(ffv4), .ff_op(ffop4), .ff_a(ffa4), .ff_b(ffb4), .ff_c(ffc4)
`endif
  );

  alu_result_checker #(.WIDTH(8), .CNT_W(16), .EXPECT_COUNT(1)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(rdy1), .op(op), .a(a), .b(b), .c(c),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch(mis1),
    .vec_cnt(vec1), .fail_cnt(fail1)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .ff_valid(ffv1), .ff_op(ffop1), .ff_a(ffa1), .ff_b(ffb1), .ff_c(ffc1)
`endif
  );

  alu_result_checker #(.WIDTH(8), .CNT_W(2), .EXPECT_COUNT(3)) ds (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(rdys), .op(op), .a(a), .b(b), .c(c),
    .busy(busys), .done(dones), .pass(passs), .mismatch(miss),
    .vec_cnt(vecs), .fail_cnt(fails)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .ff_valid(ffvs), .ff_op(ffops), .ff_a(ffas), .ff_b(ffbs), .ff_c(ffcs)
`endif
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       exp_mis;
  } vec_t;

  vec_t tbl [8];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    op = 2'b00; a = 8'h00; b = 8'h00; c = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] z);
    in_valid = 1'b1;
    op = o; a = x; b = y; c = z;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_fail;
    int n_acc;
    int pat [6];

    // run 0: all correct (XOR, AND, OR, ADD with carry dropped)
    tbl[0] = '{2'b00, 8'hAA, 8'h55, 8'hFF, 1'b0};
    tbl[1] = '{2'b01, 8'hF0, 8'h3C, 8'h30, 1'b0};
    tbl[2] = '{2'b10, 8'h0F, 8'hF0, 8'hFF, 1'b0};
    tbl[3] = '{2'b11, 8'hFF, 8'h02, 8'h01, 1'b0};
    // run 1: second vector wrong
    tbl[4] = '{2'b11, 8'h80, 8'h80, 8'h00, 1'b0};
    tbl[5] = '{2'b00, 8'hAA, 8'h55, 8'h00, 1'b1};
    tbl[6] = '{2'b01, 8'hFF, 8'h0F, 8'h0F, 1'b0};
    tbl[7] = '{2'b10, 8'h00, 8'h00, 8'h00, 1'b0};
    pat = '{1, 0, 1, 1, 0, 1};

    // ---------------- reset state ----------------
    do_reset();
    check("reset in_ready", rdy4, 0);
    check("reset busy", busy4, 0);
    check("reset done", done4, 0);
    check("reset pass", pass4, 0);
    check("reset mismatch", mis4, 0);
    check("reset vec_cnt", vec4, 0);
    check("reset fail_cnt", fail4, 0);

    // ---------------- single vector (EXPECT_COUNT=1) ----------------
    do_start();
    check("one busy", busy1, 1);
    drive(2'b00, 8'hAA, 8'h55, 8'hFF);
    tick();
    $display("vec one: op=0 a=aa b=55 c=ff");
    in_valid = 1'b0;
    check("one in_ready after accept", rdy1, 0);
    tick();
    check("one vec_cnt", vec1, 1);
    check("one mismatch", mis1, 0);
    check("one done early", done1, 0);
    tick();
    check("one done", done1, 1);
    check("one pass", pass1, 1);
    check("one fail_cnt", fail1, 0);
    check("one busy end", busy1, 0);

    // ---------------- table runs, back-to-back ----------------
    for (int r = 0; r < 2; r++) begin
      do_reset();
      do_start();
      exp_fail = 0;
      for (int i = 0; i < 4; i++) exp_fail += int'(tbl[4*r+i].exp_mis);
      for (int i = 0; i < 4; i++) begin
        drive(tbl[4*r+i].op, tbl[4*r+i].a, tbl[4*r+i].b, tbl[4*r+i].c);
        tick();
        $display("run %0d vec %0d: op=%0d a=%h b=%h c=%h", r, i,
                 tbl[4*r+i].op, tbl[4*r+i].a, tbl[4*r+i].b, tbl[4*r+i].c);
        check($sformatf("run%0d in_ready %0d", r, i), rdy4, (i < 3) ? 1 : 0);
        if (i > 0)
          check($sformatf("run%0d mismatch %0d", r, i - 1), mis4, tbl[4*r+i-1].exp_mis);
      end
      in_valid = 1'b0;
      tick();
      check($sformatf("run%0d mismatch 3", r), mis4, tbl[4*r+3].exp_mis);
      check($sformatf("run%0d vec_cnt", r), vec4, 4);
      check($sformatf("run%0d fail_cnt", r), fail4, exp_fail);
      check($sformatf("run%0d done early", r), done4, 0);
      tick();
      check($sformatf("run%0d done", r), done4, 1);
      check($sformatf("run%0d pass", r), pass4, (exp_fail == 0) ? 1 : 0);
      check($sformatf("run%0d busy end", r), busy4, 0);
      check($sformatf("run%0d mismatch end", r), mis4, 0);
`ifdef FIRST_FAIL_CAPTURE_EN
      check($sformatf("run%0d ff_valid", r), ffv4, r);
      if (r == 1) begin
        check("ff_op", ffop4, 2'b00);
        check("ff_a", ffa4, 8'hAA);
        check("ff_b", ffb4, 8'h55);
        check("ff_c", ffc4, 8'h00);
      end
`endif
    end

    // ---------------- gapped in_valid ----------------
    do_reset();
    do_start();
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = pat[k][0];
      op = 2'b01; a = 8'(k + 1); b = 8'hFF; c = 8'(k + 1);
      tick();
      n_acc += pat[k];
      $display("gap cycle %0d: in_valid=%0d a=%h", k, pat[k], 8'(k + 1));
      check($sformatf("gap in_ready %0d", k), rdy4, (n_acc < 4) ? 1 : 0);
    end
    check("gap vec_cnt mid", vec4, 3);
    drive(2'b00, 8'h00, 8'h00, 8'h5A);
    tick();
    check("gap in_ready full", rdy4, 0);
    check("gap vec_cnt", vec4, 4);
    check("gap mismatch", mis4, 0);
    tick();
    check("gap done", done4, 1);
    tick();
    in_valid = 1'b0;
    check("gap done hold vec", vec4, 4);
    check("gap done hold fail", fail4, 0);
    check("gap done pass", pass4, 1);

    // ---------------- reset with failing vector in flight ----------------
    do_reset();
    do_start();
    drive(2'b00, 8'hAA, 8'h55, 8'h00);
    tick();
    $display("inflight vec: op=0 a=aa b=55 c=00");
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("inflight mismatch", mis4, 0);
    check("inflight busy", busy4, 0);
    check("inflight in_ready", rdy4, 0);
    check("inflight vec_cnt", vec4, 0);
    check("inflight fail_cnt", fail4, 0);
    check("inflight done", done4, 0);
    rst_n = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c);
      tick();
      $display("clean vec %0d: op=%0d a=%h", i, tbl[i].op, tbl[i].a);
      check($sformatf("clean mismatch %0d", i), mis4, 0);
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("clean done", done4, 1);
    check("clean pass", pass4, 1);
    check("clean vec_cnt", vec4, 4);

    // ---------------- saturating all-fail run, start while busy ----------------
    do_reset();
    do_start();
    drive(2'b10, 8'h01, 8'h02, 8'h00);
    tick();
    $display("sat vec 0: op=2 a=01 b=02 c=00");
    drive(2'b11, 8'h01, 8'h01, 8'h03);
    start = 1'b1;
    tick();
    $display("sat vec 1: op=3 a=01 b=01 c=03 with start");
    start = 1'b0;
    check("sat busy after start", busys, 1);
    check("sat mismatch 0", miss, 1);
    drive(2'b01, 8'hFF, 8'hFF, 8'h00);
    tick();
    $display("sat vec 2: op=1 a=ff b=ff c=00");
    in_valid = 1'b0;
    check("sat in_ready full", rdys, 0);
    check("sat vec_cnt mid", vecs, 2);
    tick();
    check("sat mismatch 2", miss, 1);
    tick();
    check("sat done", dones, 1);
    check("sat fail_cnt", fails, 3);
    check("sat vec_cnt", vecs, 3);
    check("sat pass", passs, 0);
    check("sat d4 still busy", busy4, 1);
    check("sat d4 vec_cnt", vec4, 3);
    check("sat d4 fail_cnt", fail4, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
